// File: rtl/mdio_reg_arbiter_if.sv
// Request-side and MAC-side register-access bundle for mdio_reg_arbiter.
// master = arbiter view; slave = requesters plus MAC view.
interface mdio_reg_arbiter_if #(
   parameter int NUM_REQ = 2
);
   logic [NUM_REQ-1:0]    req_vld;
   logic [NUM_REQ-1:0]    req_write;
   logic [5*NUM_REQ-1:0]  req_addr;
   logic [16*NUM_REQ-1:0] req_wval;
   logic [NUM_REQ-1:0]    req_ack;
   logic                  req_err;
   logic [15:0]           req_rval;

   logic                  reg_vld;
   logic                  reg_write;
   logic [4:0]            reg_addr;
   logic [15:0]           reg_wval;
   logic [15:0]           reg_rval;
   logic                  reg_ack;

   modport master (
      input  req_vld, req_write, req_addr, req_wval, reg_rval, reg_ack,
      output req_ack, req_err, req_rval, reg_vld, reg_write, reg_addr, reg_wval
   );

   modport slave (
      output req_vld, req_write, req_addr, req_wval, reg_rval, reg_ack,
      input  req_ack, req_err, req_rval, reg_vld, reg_write, reg_addr, reg_wval
   );
endinterface

// File: rtl/mdio_reg_arbiter.sv
// Round-robin arbiter sharing the MAC PHY-register port between NUM_REQ requesters,
// with ack timeout. Define STATUS_POLL_EN for the periodic BMSR link-status poll.
module mdio_reg_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 65535,
   parameter int POLL_CYCLES    = 2097152
) (
   input  logic               clk_mac,
   input  logic               rst,
   mdio_reg_arbiter_if.master bus,
   output logic               busy,
   output logic               link_up,
   output logic               an_done
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int IW1   = IDX_W + 1;
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

   state_t             state, state_d;
   logic [IDX_W-1:0]   rr, rr_d, gnt, gnt_d, pick;
   logic               found;
   logic               poll_own, poll_own_d, poll_go;
   logic [CNT_W-1:0]   cnt, cnt_d;
   logic               vld_q, vld_d, write_q, write_d;
   logic [4:0]         addr_q, addr_d;
   logic [15:0]        wval_q, wval_d, rval_q, rval_d;
   logic [NUM_REQ-1:0] ack_q, ack_d;
   logic               err_q, err_d, busy_d;

   assign bus.reg_vld   = vld_q;
   assign bus.reg_write = write_q;
   assign bus.reg_addr  = addr_q;
   assign bus.reg_wval  = wval_q;
   assign bus.req_ack   = ack_q;
   assign bus.req_err   = err_q;
   assign bus.req_rval  = rval_q;

   // First pending requester at or after rr, wrapping modulo NUM_REQ.
   always_comb begin
      logic [IW1-1:0] cand;
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = {1'b0, rr} + IW1'(i);
         if (cand >= IW1'(NUM_REQ)) cand = cand - IW1'(NUM_REQ);
         if (!found && bus.req_vld[cand[IDX_W-1:0]]) begin
            found = 1'b1;
            pick  = cand[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      // NOTE: every signal gets a default first so no path through the case infers a latch.
      state_d    = state;
      rr_d       = rr;
      gnt_d      = gnt;
      poll_own_d = poll_own;
      cnt_d      = cnt;
      vld_d      = vld_q;
      write_d    = write_q;
      addr_d     = addr_q;
      wval_d     = wval_q;
      rval_d     = rval_q;
      ack_d      = '0;
      err_d      = 1'b0;
      unique case (state)
         IDLE: begin
            if (found) begin
               gnt_d      = pick;
               poll_own_d = 1'b0;
               vld_d      = 1'b1;
               write_d    = bus.req_write[pick];
               addr_d     = bus.req_addr[5*pick +: 5];
               wval_d     = bus.req_wval[16*pick +: 16];
               cnt_d      = '0;
               state_d    = BUSY;
            end else if (poll_go) begin
               poll_own_d = 1'b1;
               vld_d      = 1'b1;
               write_d    = 1'b0;
               addr_d     = 5'd1;
               wval_d     = '0;
               cnt_d      = '0;
               state_d    = BUSY;
            end
         end
         BUSY: begin
            // An ack arriving on the timeout cycle still counts as success.
            if (bus.reg_ack || cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               vld_d   = 1'b0;
               state_d = ACK;
               if (!poll_own) begin
                  ack_d[gnt] = 1'b1;
                  err_d      = !bus.reg_ack;
                  rval_d     = bus.reg_ack ? bus.reg_rval : 16'hFFFF;
               end
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         ACK: begin
            state_d = IDLE;
            if (!poll_own) rr_d = (gnt == IDX_W'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_mac) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) begin
         state    <= IDLE;
         rr       <= '0;
         gnt      <= '0;
         poll_own <= 1'b0;
         cnt      <= '0;
         vld_q    <= 1'b0;
         write_q  <= 1'b0;
         addr_q   <= '0;
         wval_q   <= '0;
         rval_q   <= '0;
         ack_q    <= '0;
         err_q    <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_d;
         rr       <= rr_d;
         gnt      <= gnt_d;
         poll_own <= poll_own_d;
         cnt      <= cnt_d;
         vld_q    <= vld_d;
         write_q  <= write_d;
         addr_q   <= addr_d;
         wval_q   <= wval_d;
         rval_q   <= rval_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
         busy     <= busy_d;
      end
   end

`ifdef STATUS_POLL_EN
   localparam int PCNT_W = $clog2(POLL_CYCLES);

   logic [PCNT_W-1:0] poll_cnt;
   logic              poll_pend, poll_wrap, poll_issue, link_q, an_q;

   assign poll_wrap  = (poll_cnt == PCNT_W'(POLL_CYCLES - 1));
   assign poll_go    = poll_pend && (bus.req_vld == '0);
   assign poll_issue = (state == IDLE) && !found && poll_go;

   // A wrap while a poll is already pending collapses into that one poll.
   always_ff @(posedge clk_mac) begin
      if (rst) begin
         poll_cnt  <= '0;
         poll_pend <= 1'b0;
         link_q    <= 1'b0;
         an_q      <= 1'b0;
      end else begin
         poll_cnt <= poll_wrap ? '0 : poll_cnt + 1'b1;
         if (poll_issue)     poll_pend <= 1'b0;
         else if (poll_wrap) poll_pend <= 1'b1;
         if (state == BUSY && poll_own && bus.reg_ack) begin
            link_q <= bus.reg_rval[2];
            an_q   <= bus.reg_rval[5];
         end
      end
   end

   assign link_up = link_q;
   assign an_done = an_q;
`else
   assign poll_go = 1'b0;
   assign link_up = 1'b0;
   assign an_done = 1'b0;
`endif

endmodule

// File: tb/tb_mdio_reg_arbiter.sv
// Directed self-checking bench for mdio_reg_arbiter: arbitration order, latency,
// timeout, reset mid-transaction and (with STATUS_POLL_EN) the status poll.
module tb_mdio_reg_arbiter;
   localparam int NREQ = 2;

   logic clk_mac = 1'b0;
   logic rst;
   logic busy, link_up, an_done;

   int          n_tests = 0;
   int          n_fail  = 0;
   bit          mac_silent;
   int          mac_delay;
   int          mac_cnt;
   logic [15:0] mac_rval;

   mdio_reg_arbiter_if #(.NUM_REQ(NREQ)) bus();

   mdio_reg_arbiter #(
      .NUM_REQ       (NREQ),
      .TIMEOUT_CYCLES(16),
      .POLL_CYCLES   (100)
   ) dut (
      .clk_mac(clk_mac),
      .rst    (rst),
      .bus    (bus.master),
      .busy   (busy),
      .link_up(link_up),
      .an_done(an_done)
   );

   always #5 clk_mac = ~clk_mac;

   // MAC model: acks mac_delay cycles after first seeing reg_vld, unless silenced.
   initial begin
      bus.reg_ack  = 1'b0;
      bus.reg_rval = '0;
      mac_cnt      = 0;
      forever begin
         @(posedge clk_mac);
         #1;
         bus.reg_ack = 1'b0;
         if (bus.reg_vld && !mac_silent && !rst) begin
            if (mac_cnt == mac_delay) begin
               bus.reg_ack  = 1'b1;
               bus.reg_rval = mac_rval;
               mac_cnt      = 0;
            end else begin
               mac_cnt++;
            end
         end else begin
            mac_cnt = 0;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk_mac);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input bit v, input bit w, input logic [4:0] a,
                          input logic [15:0] d);
      bus.req_vld[i]           = v;
      bus.req_write[i]         = w;
      bus.req_addr[5*i +: 5]   = a;
      bus.req_wval[16*i +: 16] = d;
   endtask

   task automatic wait_vld(output int cyc);
      cyc = 0;
      while (!bus.reg_vld && cyc < 300) begin
         tick();
         cyc++;
      end
      if (!bus.reg_vld) check("wait_reg_vld_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_ack(output int cyc);
      cyc = 0;
      while (bus.req_ack == '0 && cyc < 300) begin
         tick();
         cyc++;
      end
      if (bus.req_ack == '0) check("wait_req_ack_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_fall(output int cyc);
      cyc = 0;
      while (bus.reg_vld && cyc < 300) begin
         tick();
         cyc++;
      end
      if (bus.reg_vld) check("wait_reg_vld_fall_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int c;
      rst          = 1'b1;
      bus.req_vld  = '0;
      bus.req_write = '0;
      bus.req_addr = '0;
      bus.req_wval = '0;
      mac_silent   = 1'b0;
      mac_delay    = 10;
      mac_rval     = 16'h782D;
      repeat (3) tick();

      // Reset state
      check("rst_reg_vld", 32'(bus.reg_vld), 32'd0);
      check("rst_req_ack", 32'(bus.req_ack), 32'd0);
      check("rst_req_err", 32'(bus.req_err), 32'd0);
      check("rst_req_rval", 32'(bus.req_rval), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      tick();

      // 1: simultaneous requests, req0 served first, req1 at ack+2
      set_req(0, 1'b1, 1'b0, 5'd1, 16'h0000);
      set_req(1, 1'b1, 1'b1, 5'd4, 16'h0001);
      wait_vld(c);
      check("t1_grant_latency", 32'(c), 32'd1);
      check("t1_addr0", 32'(bus.reg_addr), 32'd1);
      check("t1_write0", 32'(bus.reg_write), 32'd0);
      wait_ack(c);
      check("t1_ack_latency", 32'(c), 32'd11);
      check("t1_ack0", 32'(bus.req_ack), 32'b01);
      check("t1_rval0", 32'(bus.req_rval), 32'h782D);
      check("t1_err0", 32'(bus.req_err), 32'd0);
      check("t1_busy_in_ack", 32'(busy), 32'd1);
      set_req(0, 1'b0, 1'b0, 5'd1, 16'h0000);
      wait_vld(c);
      check("t1_regrant_gap", 32'(c), 32'd2);
      check("t1_addr1", 32'(bus.reg_addr), 32'd4);
      check("t1_write1", 32'(bus.reg_write), 32'd1);
      check("t1_wval1", 32'(bus.reg_wval), 32'h0001);
      wait_ack(c);
      check("t1_ack1", 32'(bus.req_ack), 32'b10);
      set_req(1, 1'b0, 1'b0, 5'd0, 16'h0000);
      tick();
      check("t1_ack_one_cycle", 32'(bus.req_ack), 32'd0);

      // 2: both held continuously, grants alternate
      set_req(0, 1'b1, 1'b0, 5'd2, 16'h0000);
      set_req(1, 1'b1, 1'b0, 5'd3, 16'h0000);
      for (int k = 0; k < 6; k++) begin
         wait_vld(c);
         check($sformatf("t2_addr_%0d", k), 32'(bus.reg_addr), (k % 2 == 0) ? 32'd2 : 32'd3);
         wait_ack(c);
         check($sformatf("t2_ack_%0d", k), 32'(bus.req_ack), (k % 2 == 0) ? 32'b01 : 32'b10);
      end
      set_req(0, 1'b0, 1'b0, 5'd0, 16'h0000);
      set_req(1, 1'b0, 1'b0, 5'd0, 16'h0000);
      tick();
      tick();

      // 3: timeout after exactly 16 cycles, then normal service
      mac_silent = 1'b1;
      set_req(0, 1'b1, 1'b0, 5'd7, 16'h0000);
      wait_vld(c);
      check("t3_addr", 32'(bus.reg_addr), 32'd7);
      wait_fall(c);
      check("t3_timeout_cycles", 32'(c), 32'd16);
      check("t3_ack", 32'(bus.req_ack), 32'b01);
      check("t3_err", 32'(bus.req_err), 32'd1);
      check("t3_rval", 32'(bus.req_rval), 32'hFFFF);
      set_req(0, 1'b0, 1'b0, 5'd0, 16'h0000);
      mac_silent = 1'b0;
      set_req(1, 1'b1, 1'b1, 5'd9, 16'hBEEF);
      wait_vld(c);
      check("t3_next_addr", 32'(bus.reg_addr), 32'd9);
      check("t3_next_wval", 32'(bus.reg_wval), 32'hBEEF);
      wait_ack(c);
      check("t3_next_ack", 32'(bus.req_ack), 32'b10);
      check("t3_next_err", 32'(bus.req_err), 32'd0);
      set_req(1, 1'b0, 1'b0, 5'd0, 16'h0000);
      tick();
      tick();

      // 4: move rr to 1, then reset mid-BUSY; rr must return to 0
      set_req(0, 1'b1, 1'b0, 5'd5, 16'h0000);
      wait_vld(c);
      wait_ack(c);
      set_req(0, 1'b0, 1'b0, 5'd5, 16'h0000);
      mac_silent = 1'b1;
      set_req(1, 1'b1, 1'b0, 5'd6, 16'h0000);
      wait_vld(c);
      check("t4_busy_addr", 32'(bus.reg_addr), 32'd6);
      tick();
      tick();
      rst = 1'b1;
      tick();
      check("t4_rst_reg_vld", 32'(bus.reg_vld), 32'd0);
      check("t4_rst_req_ack", 32'(bus.req_ack), 32'd0);
      check("t4_rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      mac_silent = 1'b0;
      set_req(0, 1'b1, 1'b0, 5'd5, 16'h0000);
      wait_vld(c);
      check("t4_post_rst_latency", 32'(c), 32'd1);
      check("t4_post_rst_grant", 32'(bus.reg_addr), 32'd5);
      wait_ack(c);
      check("t4_post_rst_ack0", 32'(bus.req_ack), 32'b01);
      set_req(0, 1'b0, 1'b0, 5'd0, 16'h0000);
      wait_vld(c);
      check("t4_then_req1", 32'(bus.reg_addr), 32'd6);
      wait_ack(c);
      check("t4_ack1", 32'(bus.req_ack), 32'b10);
      set_req(1, 1'b0, 1'b0, 5'd0, 16'h0000);
      tick();
      tick();

`ifdef STATUS_POLL_EN
      // 5: periodic BMSR poll, lowest priority
      mac_rval = 16'h0024;
      wait_vld(c);
      check("t5_poll_addr", 32'(bus.reg_addr), 32'd1);
      check("t5_poll_read", 32'(bus.reg_write), 32'd0);
      wait_fall(c);
      check("t5_poll_no_ack", 32'(bus.req_ack), 32'd0);
      check("t5_link_up", 32'(link_up), 32'd1);
      check("t5_an_done", 32'(an_done), 32'd1);
      begin
         int gap;
         gap = c;
         wait_vld(c);
         check("t5_poll_period", 32'(gap + c), 32'd100);
         check("t5_poll2_addr", 32'(bus.reg_addr), 32'd1);
      end
      wait_fall(c);
      set_req(0, 1'b1, 1'b0, 5'd3, 16'h0000);
      for (int k = 0; k < 9; k++) begin
         wait_vld(c);
         check($sformatf("t5_held_addr_%0d", k), 32'(bus.reg_addr), 32'd3);
         wait_ack(c);
      end
      set_req(0, 1'b0, 1'b0, 5'd0, 16'h0000);
      wait_vld(c);
      check("t5_deferred_poll_addr", 32'(bus.reg_addr), 32'd1);
      wait_fall(c);
`else
      check("t5_link_up_const", 32'(link_up), 32'd0);
      check("t5_an_done_const", 32'(an_done), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
